jtkiwi_vtimer: RTL and testbench

JTKIWI_VTIMER -- requirements
Module: jtkiwi_vtimer

---
 rtl/jtkiwi_pkg.sv | 28 ++
 rtl/jtkiwi_vtimer_cen.sv | 24 ++
 rtl/jtkiwi_vtimer.sv | 93 +++++++++
 tb/tb_jtkiwi_vtimer.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/jtkiwi_pkg.sv
// Shared video timing defaults for the Kiwi video path (vtimer and video top).
// Helpers here are pure combinational utilities on 9-bit counters.
package jtkiwi_pkg;

    localparam int DEF_HTOTAL   = 384;
    localparam int DEF_VTOTAL   = 264;
    localparam int DEF_HB_START = 256;
    localparam int DEF_VB_START = 240;
    localparam int DEF_VB_END   = 16;
    localparam int DEF_HS_START = 288;
    localparam int DEF_HS_LEN   = 32;
    localparam int DEF_VS_START = 248;
    localparam int DEF_VS_LEN   = 4;

    typedef logic [8:0] cnt_t;

    // True when v lies in the half-open window [lo, lo+len).
    function automatic logic in_window(input cnt_t v, input int lo, input int len);
        int vi;
        vi = int'(v);
        return (vi >= lo) && (vi < lo + len);
    endfunction

    function automatic cnt_t wrap_inc(input cnt_t v, input cnt_t last);
        return (v == last) ? '0 : v + 9'd1;
    endfunction

endpackage

// File: rtl/jtkiwi_vtimer_cen.sv
// Pixel clock enables derived from a free-running 2-bit divider on clk.
// Enables are registered so the first pxl_cen after reset lands on the 4th clk.
module jtkiwi_vtimer_cen (
    input  logic clk,
    input  logic rstn,
    output logic pxl2_cen,
    output logic pxl_cen
);

    logic [1:0] div_reg;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            div_reg  <= 2'd0;
            pxl2_cen <= 1'b0;
            pxl_cen  <= 1'b0;
        end else begin
            div_reg  <= div_reg + 2'd1;
            pxl2_cen <= div_reg[0];
            pxl_cen  <= (div_reg == 2'd3);
        end
    end

endmodule

// File: rtl/jtkiwi_vtimer.sv
// Video timing generator: pixel/line counters, blanking, sync, vblank irq
// and the flip-adjusted line the renderer prepares next.
module jtkiwi_vtimer
    import jtkiwi_pkg::*;
#(
    parameter int HTOTAL   = DEF_HTOTAL,
    parameter int VTOTAL   = DEF_VTOTAL,
    parameter int HB_START = DEF_HB_START,
    parameter int VB_START = DEF_VB_START,
    parameter int VB_END   = DEF_VB_END,
    parameter int HS_START = DEF_HS_START,
    parameter int HS_LEN   = DEF_HS_LEN,
    parameter int VS_START = DEF_VS_START,
    parameter int VS_LEN   = DEF_VS_LEN
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       flip,
    input  logic       irq_ack,
    output logic       pxl2_cen,
    output logic       pxl_cen,
    output logic [8:0] hdump,
    output logic [8:0] vdump,
    output logic [8:0] vrender,
    output logic       LHBL,
    output logic       LVBL,
    output logic       HS,
    output logic       VS,
    output logic       irq_n
);

    localparam cnt_t H_LAST  = cnt_t'(HTOTAL - 1);
    localparam cnt_t V_LAST  = cnt_t'(VTOTAL - 1);
    localparam cnt_t VB_LINE = cnt_t'(VB_START);
    localparam cnt_t HB_PIX  = cnt_t'(HB_START);

    cnt_t hdump_next;
    cnt_t vdump_next;
    cnt_t vnext_line;
    logic h_wrap;
    logic irq_set;

    jtkiwi_vtimer_cen u_cen (
        .clk      (clk),
        .rstn     (rstn),
        .pxl2_cen (pxl2_cen),
        .pxl_cen  (pxl_cen)
    );

    always_comb begin
        h_wrap     = (hdump == H_LAST);
        hdump_next = wrap_inc(hdump, H_LAST);
        vdump_next = h_wrap ? wrap_inc(vdump, V_LAST) : vdump;
        irq_set    = pxl_cen && h_wrap && (vdump_next == VB_LINE);
    end

    // Blanking/sync are computed from the next counter values so they stay
    // aligned with hdump/vdump in the same cycle.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            hdump <= '0;
            vdump <= '0;
            LHBL  <= 1'b1;
            LVBL  <= 1'b0;
            HS    <= 1'b0;
            VS    <= 1'b0;
            irq_n <= 1'b1;
        end else begin
            if (pxl_cen) begin
                hdump <= hdump_next;
                vdump <= vdump_next;
                LHBL  <= (hdump_next < HB_PIX);
                HS    <= in_window(hdump_next, HS_START, HS_LEN);
                if (h_wrap) begin
                    LVBL <= in_window(vdump_next, VB_END, VB_START - VB_END);
                    VS   <= in_window(vdump_next, VS_START, VS_LEN);
                end
            end
            // A new vblank edge takes priority over a simultaneous acknowledge.
            if (irq_set) begin
                irq_n <= 1'b0;
            end else if (irq_ack) begin
                irq_n <= 1'b1;
            end
        end
    end

    always_comb begin
        vnext_line = wrap_inc(vdump, V_LAST);
        vrender    = flip ? (V_LAST - vnext_line) : vnext_line;
    end

endmodule

// File: tb/tb_jtkiwi_vtimer.sv
// Bench for jtkiwi_vtimer: a default-timing instance and a scaled-down instance
// run side by side, both checked every cycle against a closed-form timing model.
module tb_jtkiwi_vtimer;

    localparam int DH = 384, DV = 264, DHB = 256, DVBS = 240, DVBE = 16;
    localparam int DHSS = 288, DHSL = 32, DVSS = 248, DVSL = 4;
    localparam int SH = 32, SV = 40, SHB = 16, SVBS = 30, SVBE = 4;
    localparam int SHSS = 20, SHSL = 4, SVSS = 33, SVSL = 2;
    localparam int LIM = 20000;

    logic clk = 1'b0;
    logic rstn, flip, irq_ack;

    logic       pxl2_cen_d, pxl_cen_d, lhbl_d, lvbl_d, hs_d, vs_d, irq_n_d;
    logic [8:0] hdump_d, vdump_d, vrender_d;
    logic       pxl2_cen_s, pxl_cen_s, lhbl_s, lvbl_s, hs_s, vs_s, irq_n_s;
    logic [8:0] hdump_s, vdump_s, vrender_s;

    int checks = 0;
    int errors = 0;
    int unsigned cyc = 0;
    logic irq_exp_d = 1'b1;
    logic irq_exp_s = 1'b1;
    logic started = 1'b0;
    logic first_pass = 1'b1;
    int npix_s = 0, nvb_s = 0, nvs_s = 0, nhb_d = 0, nhs_d = 0;

    always #5 clk = ~clk;

    jtkiwi_vtimer dut_d (
        .clk(clk), .rstn(rstn), .flip(flip), .irq_ack(irq_ack),
        .pxl2_cen(pxl2_cen_d), .pxl_cen(pxl_cen_d), .hdump(hdump_d), .vdump(vdump_d),
        .vrender(vrender_d), .LHBL(lhbl_d), .LVBL(lvbl_d), .HS(hs_d), .VS(vs_d),
        .irq_n(irq_n_d)
    );

    jtkiwi_vtimer #(
        .HTOTAL(SH), .VTOTAL(SV), .HB_START(SHB), .VB_START(SVBS), .VB_END(SVBE),
        .HS_START(SHSS), .HS_LEN(SHSL), .VS_START(SVSS), .VS_LEN(SVSL)
    ) dut_s (
        .clk(clk), .rstn(rstn), .flip(flip), .irq_ack(irq_ack),
        .pxl2_cen(pxl2_cen_s), .pxl_cen(pxl_cen_s), .hdump(hdump_s), .vdump(vdump_s),
        .vrender(vrender_s), .LHBL(lhbl_s), .LVBL(lvbl_s), .HS(hs_s), .VS(vs_s),
        .irq_n(irq_n_s)
    );

    task automatic check(input string name, input logic [33:0] act, input logic [33:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d actual=%h required=%h", name, cyc, act, exp);
        end
    endtask

    // Pixels elapsed after k clocks: one pixel per 4 clocks, first on clock 5.
    function automatic int pix(input int unsigned k);
        return (k >= 5) ? (int'(k) - 1) / 4 : 0;
    endfunction

    function automatic logic [33:0] exp_vec(input int unsigned k, input logic irq, input logic fl,
                                            input int H, input int V, input int HB,
                                            input int HSS, input int HSL, input int VBS,
                                            input int VBE, input int VSS, input int VSL);
        int p, h, v, v1, vr;
        p  = pix(k);
        h  = p % H;
        v  = (p / H) % V;
        v1 = (v + 1) % V;
        vr = fl ? (V - 1 - v1) : v1;
        return {(k > 0) && (k % 2 == 0), (k > 0) && (k % 4 == 0), 9'(h), 9'(v), 9'(vr),
                h < HB, (v >= VBE) && (v < VBS), (h >= HSS) && (h < HSS + HSL),
                (v >= VSS) && (v < VSS + VSL), irq};
    endfunction

    // Model state: clock count since reset and expected irq level per instance.
    always @(posedge clk or negedge rstn) begin : model
        int p_old, p_new;
        if (!rstn) begin
            cyc       = 0;
            irq_exp_d = 1'b1;
            irq_exp_s = 1'b1;
        end else begin
            p_old = pix(cyc);
            cyc   = cyc + 1;
            p_new = pix(cyc);
            if (p_old != p_new && p_new % (DH * DV) == DVBS * DH) irq_exp_d = 1'b0;
            else if (irq_ack) irq_exp_d = 1'b1;
            if (p_old != p_new && p_new % (SH * SV) == SVBS * SH) irq_exp_s = 1'b0;
            else if (irq_ack) irq_exp_s = 1'b1;
        end
    end

    always @(negedge clk) begin
        if (started) begin
            check("cmp_dflt", {pxl2_cen_d, pxl_cen_d, hdump_d, vdump_d, vrender_d,
                               lhbl_d, lvbl_d, hs_d, vs_d, irq_n_d},
                  exp_vec(cyc, irq_exp_d, flip, DH, DV, DHB, DHSS, DHSL, DVBS, DVBE, DVSS, DVSL));
            check("cmp_small", {pxl2_cen_s, pxl_cen_s, hdump_s, vdump_s, vrender_s,
                                lhbl_s, lvbl_s, hs_s, vs_s, irq_n_s},
                  exp_vec(cyc, irq_exp_s, flip, SH, SV, SHB, SHSS, SHSL, SVBS, SVBE, SVSS, SVSL));
        end
    end

    // Per-line and per-frame occupancy counts during the first run.
    always @(negedge clk) begin
        if (rstn && first_pass && cyc >= 1 && cyc <= SH * SV * 4) begin
            if (pxl_cen_s) begin
                npix_s++;
                if (hdump_s == 9'd0 && !lvbl_s) nvb_s++;
                if (hdump_s == 9'd0 && vs_s) nvs_s++;
            end
        end
        if (rstn && first_pass && cyc >= 1 && cyc <= DH * 4 && pxl_cen_d) begin
            if (!lhbl_d) nhb_d++;
            if (hs_d) nhs_d++;
        end
    end

    initial begin : stim
        logic [15:0] pc, p2;
        int n;
        rstn = 1'b0; flip = 1'b0; irq_ack = 1'b0;
        repeat (3) @(posedge clk);
        started = 1'b1;
        @(negedge clk);
        rstn = 1'b1;

        for (int i = 0; i < 16; i++) begin
            @(posedge clk); #1;
            pc[i] = pxl_cen_d;
            p2[i] = pxl2_cen_d;
        end
        check("pxl_cen_pattern", 34'(pc), 34'h8888);
        check("pxl2_cen_pattern", 34'(p2), 34'haaaa);

        n = 0;
        while (hdump_d != 9'd383 && n < LIM) begin @(negedge clk); n++; end
        check("h383_cycle", 34'(cyc), 34'd1533);
        n = 0;
        while (hdump_d == 9'd383 && n < LIM) begin @(negedge clk); n++; end
        check("h_wrap_vals", {16'd0, hdump_d, vdump_d}, {16'd0, 9'd0, 9'd1});
        check("h_wrap_cycle", 34'(cyc), 34'd1537);
        check("lhbl_low_pixels", 34'(nhb_d), 34'd128);
        check("hs_pixels", 34'(nhs_d), 34'd32);

        n = 0;
        while (irq_n_s && n < LIM) begin @(negedge clk); n++; end
        check("irq_timeout", 34'(n < LIM), 34'd1);
        check("irq_cycle", 34'(cyc), 34'd3841);
        check("irq_pos", {15'd0, vdump_s, hdump_s, lvbl_s}, {15'd0, 9'd30, 9'd0, 1'b0});
        repeat (100) @(negedge clk);
        check("irq_held", 34'(irq_n_s), 34'd0);
        irq_ack = 1'b1;
        @(negedge clk);
        irq_ack = 1'b0;
        check("irq_ack_clear", 34'(irq_n_s), 34'd1);
        repeat (5) @(negedge clk);
        irq_ack = 1'b1;
        @(negedge clk);
        irq_ack = 1'b0;
        check("ack_when_high", 34'(irq_n_s), 34'd1);

        n = 0;
        while (vdump_s != 9'd39 && n < LIM) begin @(negedge clk); n++; end
        check("v39_cycle", 34'(cyc), 34'd4993);
        @(posedge clk); #3;
        check("vrender_wrap", 34'(vrender_s), 34'd0);
        flip = 1'b1; #1;
        check("vrender_wrap_flip", 34'(vrender_s), 34'd39);
        @(posedge clk); #3;
        flip = 1'b0;
        n = 0;
        while (vdump_s != 9'd0 && n < LIM) begin @(negedge clk); n++; end
        check("frame_cycle", 34'(cyc), 34'd5121);
        check("frame_pixels", 34'(npix_s), 34'd1280);
        check("vblank_lines", 34'(nvb_s), 34'd14);
        check("vs_lines", 34'(nvs_s), 34'd2);

        n = 0;
        while (cyc != 8960 && n < LIM) begin @(negedge clk); n++; end
        check("pre_assert_high", 34'(irq_n_s), 34'd1);
        irq_ack = 1'b1;
        @(negedge clk);
        irq_ack = 1'b0;
        check("ack_vs_assert", {24'd0, vdump_s, irq_n_s}, {24'd0, 9'd30, 1'b0});

        n = 0;
        while (vdump_d != 9'd10 && n < LIM) begin @(negedge clk); n++; end
        check("v10_cycle", 34'(cyc), 34'd15361);
        @(posedge clk); #3;
        flip = 1'b1; #1;
        check("vrender_flip", 34'(vrender_d), 34'd252);
        flip = 1'b0; #1;
        check("vrender_noflip", 34'(vrender_d), 34'd11);

        n = 0;
        while (vdump_s != 9'd33 && n < LIM) begin @(negedge clk); n++; end
        check("pre_reset_irq", {25'd0, vdump_s}, {25'd0, 9'd33});
        check("pre_reset_irq_low", 34'(irq_n_s), 34'd0);
        first_pass = 1'b0;
        @(posedge clk); #2;
        rstn = 1'b0; #1;
        check("reset_dflt", {pxl2_cen_d, pxl_cen_d, hdump_d, vdump_d, vrender_d,
                             lhbl_d, lvbl_d, hs_d, vs_d, irq_n_d},
              {2'b00, 9'd0, 9'd0, 9'd1, 5'b10001});
        check("reset_small", {pxl2_cen_s, pxl_cen_s, hdump_s, vdump_s, vrender_s,
                              lhbl_s, lvbl_s, hs_s, vs_s, irq_n_s},
              {2'b00, 9'd0, 9'd0, 9'd1, 5'b10001});
        repeat (3) @(negedge clk);
        rstn = 1'b1;
        repeat (12) @(negedge clk);
        check("post_reset_h", 34'(hdump_s), 34'd2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
